// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        INT_DRAIN = 2'd2,
        INT_ENTER = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [3:0] REG_ZERO = 4'd0;

    // A destination only matches a source when it is a real register (R0 is hardwired zero).
    function automatic logic reg_match(input logic [3:0] dst, input logic [3:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Bypass select for one ID source operand; the younger MEM result wins over WB.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [3:0] rs,
    input  logic [3:0] mem_reg_dst,
    input  logic       mem_reg_wr,
    input  logic [3:0] wb_reg_dst,
    input  logic       wb_reg_wr,
    output logic [1:0] sel
);

    // Priority compare: MEM stage first, then WB, else register file.
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_wr && reg_match(mem_reg_dst, rs)) begin
            sel = FWD_EXMEM;
        end else if (wb_reg_wr && reg_match(wb_reg_dst, rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: stall/flush sequencing for memory waits,
// redirects, load-use bubbles and interrupt entry, plus ID bypass selects.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [3:0] ex_reg_dst,
    input  logic       ex_reg_wr,
    input  logic       ex_wb_sel,
    input  logic [3:0] mem_reg_dst,
    input  logic       mem_reg_wr,
    input  logic [3:0] wb_reg_dst,
    input  logic       wb_reg_wr,
    input  logic       redirect_ex,
    input  logic       returni_ex,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       interrupt_req,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       ex_mem_flush,
    output logic       mem_wb_stall,
    output logic       mem_wb_flush,
    output logic [1:0] fwd_sel_rs1,
    output logic [1:0] fwd_sel_rs2,
    output logic       int_ack,
    output logic       int_active,
    output logic       mem_err
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    // The counter holds the number of wait cycles already elapsed, so the
    // timeout fires in the wait cycle whose ordinal equals MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             int_active_nxt;
    logic [1:0]       fwd1_raw, fwd2_raw;
    logic             mem_wait, redirect, load_use;
    logic             freeze, run_hazards;

    fwd_unit u_fwd_rs1 (
        .rs          (id_rs1),
        .mem_reg_dst (mem_reg_dst),
        .mem_reg_wr  (mem_reg_wr),
        .wb_reg_dst  (wb_reg_dst),
        .wb_reg_wr   (wb_reg_wr),
        .sel         (fwd1_raw)
    );

    fwd_unit u_fwd_rs2 (
        .rs          (id_rs2),
        .mem_reg_dst (mem_reg_dst),
        .mem_reg_wr  (mem_reg_wr),
        .wb_reg_dst  (wb_reg_dst),
        .wb_reg_wr   (wb_reg_wr),
        .sel         (fwd2_raw)
    );

    assign mem_wait = mem_req && !mem_ready;
    assign redirect = redirect_ex || returni_ex;
    assign load_use = ex_reg_wr && ex_wb_sel &&
                      ((id_rs1_used && reg_match(ex_reg_dst, id_rs1)) ||
                       (id_rs2_used && reg_match(ex_reg_dst, id_rs2)));

    // State, wait/drain counter and ISR flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            int_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            int_active <= int_active_nxt;
        end
    end

    // Next-state and stall/flush/bypass outputs; everything forced low during reset.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        int_active_nxt = int_active;
        freeze         = 1'b0;
        run_hazards    = 1'b0;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_stall   = 1'b0;
        mem_wb_flush   = 1'b0;
        int_ack        = 1'b0;
        mem_err        = 1'b0;
        fwd_sel_rs1    = fwd1_raw;
        fwd_sel_rs2    = fwd2_raw;

        case (state)
            RUN: begin
                if (mem_wait) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    run_hazards = 1'b1;
                    if (interrupt_req && !int_active) begin
                        state_nxt = INT_DRAIN;
                        cnt_nxt   = '0;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Pipeline advances this cycle, so EX/ID hazards must be honoured now.
                    run_hazards = 1'b1;
                    state_nxt   = RUN;
                    cnt_nxt     = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    mem_err      = 1'b1;
                    mem_wb_flush = 1'b1;
                    state_nxt    = RUN;
                    cnt_nxt      = '0;
                end else begin
                    freeze  = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            INT_DRAIN: begin
                if (mem_wait) begin
                    freeze = 1'b1;
                end else begin
                    pc_stall = 1'b1;
                    if (redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        // Hold the dependent ID instruction rather than drop it.
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        if_id_flush = 1'b1;
                    end
                    if (cnt == DRAIN_LAST) begin
                        state_nxt = INT_ENTER;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            INT_ENTER: begin
                if (mem_wait) begin
                    freeze = 1'b1;
                end else begin
                    int_ack     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = redirect;
                    state_nxt   = RUN;
                    cnt_nxt     = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase

        if (run_hazards) begin
            if (redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end

        if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end

        if (!freeze) begin
            if (state == INT_ENTER) begin
                int_active_nxt = 1'b1;
            end else if (returni_ex) begin
                int_active_nxt = 1'b0;
            end
        end

        if (!rst_n) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_stall  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_stall = 1'b0;
            ex_mem_flush = 1'b0;
            mem_wb_stall = 1'b0;
            mem_wb_flush = 1'b0;
            int_ack      = 1'b0;
            mem_err      = 1'b0;
            fwd_sel_rs1  = FWD_RF;
            fwd_sel_rs2  = FWD_RF;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-tagged expectation scoreboard.
module tb_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int TMO   = 8;

    // Output word layout: {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f,
    //                      memwb_s, memwb_f, fwd1[1:0], fwd2[1:0], ack, active, err}
    localparam logic [15:0] NONE = 16'h0000;
    localparam logic [15:0] PC   = 16'h8000;
    localparam logic [15:0] IFS  = 16'h4000;
    localparam logic [15:0] IFF  = 16'h2000;
    localparam logic [15:0] IDS  = 16'h1000;
    localparam logic [15:0] IDF  = 16'h0800;
    localparam logic [15:0] EMS  = 16'h0400;
    localparam logic [15:0] MWS  = 16'h0100;
    localparam logic [15:0] MWF  = 16'h0080;
    localparam logic [15:0] F1M  = 16'h0020;
    localparam logic [15:0] F2M  = 16'h0008;
    localparam logic [15:0] F2W  = 16'h0010;
    localparam logic [15:0] ACK  = 16'h0004;
    localparam logic [15:0] ACT  = 16'h0002;
    localparam logic [15:0] ERR  = 16'h0001;
    localparam logic [15:0] FRZ  = PC | IFS | IDS | EMS | MWS;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] id_rs1, id_rs2, ex_reg_dst, mem_reg_dst, wb_reg_dst;
    logic id_rs1_used, id_rs2_used, ex_reg_wr, ex_wb_sel, mem_reg_wr, wb_reg_wr;
    logic redirect_ex, returni_ex, mem_req, mem_ready, interrupt_req;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
    logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic int_ack, int_active, mem_err;
    logic [15:0] act;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .MEM_TIMEOUT  (TMO),
        .CNT_W        (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_reg_dst    (ex_reg_dst),
        .ex_reg_wr     (ex_reg_wr),
        .ex_wb_sel     (ex_wb_sel),
        .mem_reg_dst   (mem_reg_dst),
        .mem_reg_wr    (mem_reg_wr),
        .wb_reg_dst    (wb_reg_dst),
        .wb_reg_wr     (wb_reg_wr),
        .redirect_ex   (redirect_ex),
        .returni_ex    (returni_ex),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .interrupt_req (interrupt_req),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_stall  (ex_mem_stall),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_stall  (mem_wb_stall),
        .mem_wb_flush  (mem_wb_flush),
        .fwd_sel_rs1   (fwd_sel_rs1),
        .fwd_sel_rs2   (fwd_sel_rs2),
        .int_ack       (int_ack),
        .int_active    (int_active),
        .mem_err       (mem_err)
    );

    assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                  ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush,
                  fwd_sel_rs1, fwd_sel_rs2, int_ack, int_active, mem_err};

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    string       name_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [15:0] m_exp;
    int          m_cyc;
    string       m_name;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on the falling edge, check every expectation tagged for this cycle.
    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            m_exp  = exp_q.pop_front();
            m_cyc  = cyc_q.pop_front();
            m_name = name_q.pop_front();
            n_tests++;
            if (m_cyc != cyc || act !== m_exp) begin
                n_fail++;
                $display("FAIL %s (cycle %0d, tagged %0d): got %h, expected %h",
                         m_name, cyc, m_cyc, act, m_exp);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [15:0] e);
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_reg_dst = 4'd0; ex_reg_wr = 1'b0; ex_wb_sel = 1'b0;
        mem_reg_dst = 4'd0; mem_reg_wr = 1'b0; wb_reg_dst = 4'd0; wb_reg_wr = 1'b0;
        redirect_ex = 1'b0; returni_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        interrupt_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;

        // Reset: outputs forced low even with hazards present on the inputs
        step();
        mem_req = 1'b1; redirect_ex = 1'b1; ex_reg_dst = 4'd5; ex_reg_wr = 1'b1;
        ex_wb_sel = 1'b1; id_rs1 = 4'd5; id_rs1_used = 1'b1;
        mem_reg_dst = 4'd5; mem_reg_wr = 1'b1;
        expect_out("reset_outputs", NONE);
        step(); rst_n = 1'b1; idle();
        expect_out("post_reset_idle", NONE);

        // Load-use
        step(); ex_reg_dst = 4'd5; ex_reg_wr = 1'b1; ex_wb_sel = 1'b1; id_rs1 = 4'd5; id_rs1_used = 1'b1;
        expect_out("load_use_rs1", PC | IFS | IDF);
        step(); ex_reg_wr = 1'b0; ex_wb_sel = 1'b0;
        expect_out("load_use_bubble", NONE);
        step(); ex_reg_dst = 4'd0; ex_reg_wr = 1'b1; ex_wb_sel = 1'b1; id_rs1 = 4'd0;
        expect_out("load_use_r0", NONE);
        step(); ex_reg_dst = 4'd7; id_rs1 = 4'd1; id_rs2 = 4'd7; id_rs2_used = 1'b1;
        expect_out("load_use_rs2", PC | IFS | IDF);
        step(); id_rs2_used = 1'b0;
        expect_out("load_use_unused", NONE);
        step(); id_rs2_used = 1'b1; ex_wb_sel = 1'b0;
        expect_out("alu_no_stall", NONE);

        // Forwarding
        step(); idle(); mem_reg_dst = 4'd3; mem_reg_wr = 1'b1; wb_reg_dst = 4'd3; wb_reg_wr = 1'b1; id_rs2 = 4'd3;
        expect_out("fwd_mem_prio", F2M);
        step(); mem_reg_wr = 1'b0;
        expect_out("fwd_wb", F2W);
        step(); id_rs2 = 4'd4;
        expect_out("fwd_none", NONE);
        step(); id_rs1 = 4'd3; mem_reg_wr = 1'b1; wb_reg_dst = 4'd4;
        expect_out("fwd_both", F1M | F2W);
        step(); mem_reg_dst = 4'd0; wb_reg_dst = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
        expect_out("fwd_r0", NONE);

        // Redirect beats load-use; returni also redirects
        step(); idle(); ex_reg_dst = 4'd5; ex_reg_wr = 1'b1; ex_wb_sel = 1'b1;
        id_rs1 = 4'd5; id_rs1_used = 1'b1; redirect_ex = 1'b1;
        expect_out("redirect_over_load_use", IFF | IDF);
        step(); idle(); returni_ex = 1'b1;
        expect_out("returni_redirect", IFF | IDF);

        // Memory wait: 4 wait cycles then ready
        step(); idle(); mem_req = 1'b1;
        expect_out("mem_wait_1", FRZ);
        step(); redirect_ex = 1'b1; interrupt_req = 1'b1;
        expect_out("mem_wait_2_ignore_redirect", FRZ);
        step(); redirect_ex = 1'b0; interrupt_req = 1'b0;
        expect_out("mem_wait_3", FRZ);
        step();
        expect_out("mem_wait_4", FRZ);
        step(); mem_ready = 1'b1;
        expect_out("mem_wait_release", NONE);
        step(); mem_req = 1'b0; mem_ready = 1'b0;
        expect_out("mem_wait_done", NONE);

        // Memory timeout after TMO wait cycles
        for (int i = 1; i < TMO; i++) begin
            step(); mem_req = 1'b1;
            expect_out($sformatf("timeout_wait_%0d", i), FRZ);
        end
        step();
        expect_out("timeout_err", MWF | ERR);
        step(); mem_req = 1'b0;
        expect_out("timeout_after", NONE);

        // Interrupt entry, nesting refused, returni exit
        step(); idle(); interrupt_req = 1'b1;
        expect_out("int_request", NONE);
        for (int i = 0; i < DRAIN; i++) begin
            step();
            expect_out($sformatf("int_drain_%0d", i), PC | IFF);
        end
        step();
        expect_out("int_ack", IFF | ACK);
        step();
        expect_out("int_active", ACT);
        step();
        expect_out("int_nested_ignored", ACT);
        step(); interrupt_req = 1'b0; returni_ex = 1'b1;
        expect_out("returni_in_isr", IFF | IDF | ACT);
        step(); returni_ex = 1'b0;
        expect_out("int_cleared", NONE);

        // Reset during MEM_WAIT
        step(); mem_req = 1'b1;
        expect_out("rst_wait_1", FRZ);
        step();
        expect_out("rst_wait_2", FRZ);
        step(); rst_n = 1'b0;
        expect_out("rst_mid_wait", NONE);
        step(); rst_n = 1'b1; mem_req = 1'b0;
        expect_out("rst_back_to_run", NONE);

        step();
        step();
        n_tests++;
        if (cyc_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", cyc_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline hazard controller that drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It also drives the rs1/rs2 bypass mux selects in ID. It detects load-use hazards, control redirects, data-memory wait states and interrupt entry/exit. It sequences the multi-cycle cases with a small FSM.

Parameters:
DRAIN_CYCLES, 3, bubble cycles injected before interrupt entry so in-flight instructions retire
MEM_TIMEOUT, 255, max consecutive data-memory wait cycles before mem_err
CNT_W, 8, width of internal wait/drain counter; must hold max(DRAIN_CYCLES, MEM_TIMEOUT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  4  source reg 1 of instruction in ID
id_rs2  in  4  source reg 2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_reg_dst  in  4  dest reg of instruction in EX
ex_reg_wr  in  1  EX instruction writes a register
ex_wb_sel  in  1  EX instruction is a load (1 = writeback from memory)
mem_reg_dst  in  4  dest reg in MEM
mem_reg_wr  in  1  MEM instruction writes a register
wb_reg_dst  in  4  dest reg in WB
wb_reg_wr  in  1  WB instruction writes a register
redirect_ex  in  1  taken branch/jump/call resolved in EX
returni_ex  in  1  returni in EX (also implies redirect)
mem_req  in  1  MEM stage data access in progress
mem_ready  in  1  data memory completes access this cycle
interrupt_req  in  1  level interrupt request
pc_stall  out  1  hold PC
if_id_stall, if_id_flush  out  1 each  IF/ID controls
id_ex_stall, id_ex_flush  out  1 each  ID/EX controls
ex_mem_stall, ex_mem_flush  out  1 each  EX/MEM controls
mem_wb_stall, mem_wb_flush  out  1 each  MEM/WB controls
fwd_sel_rs1, fwd_sel_rs2  out  2 each  0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result, 3 unused
int_ack  out  1  one-cycle pulse: vector to ISR now
int_active  out  1  ISR in progress (registered)
mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. State RUN, counter 0, int_active 0. All stall/flush outputs, int_ack and mem_err 0 during reset. fwd_sel is 0 while reset is asserted.
- Stall/flush/fwd outputs: combinational from registered state plus current inputs. int_ack and mem_err: combinational from state/counter, one cycle wide.
- R0 is hardwired zero: any dst == 0 never matches a hazard or forward.
- Forwarding (all states):
  - fwd_sel_rsN = 1 if mem_reg_wr and mem_reg_dst == id_rsN.
  - else 2 if wb_reg_wr and wb_reg_dst == id_rsN.
  - else 0. MEM has priority over WB.
- Priority in RUN: mem wait > redirect > load-use.
  - Mem wait (mem_req & !mem_ready): all four *_stall = 1, pc_stall = 1, no flushes. Go to MEM_WAIT, counter := 1.
  - Redirect (redirect_ex | returni_ex): if_id_flush = 1, id_ex_flush = 1. PC not stalled, so the target loads.
  - Load-use: ex_reg_wr & ex_wb_sel & ex_reg_dst != 0 & ((id_rs1_used & rs1 match) | (id_rs2_used & rs2 match)). Drives pc_stall = 1, if_id_stall = 1, id_ex_flush = 1. Exactly one bubble per load.
- returni_ex in any non-frozen cycle clears int_active on the next edge.
- MEM_WAIT:
  - Full freeze as above. Counter increments each cycle.
  - mem_ready = 1: freeze released the same cycle; return to RUN.
  - Counter == MEM_TIMEOUT without ready: mem_err = 1, mem_wb_flush = 1 (access dropped), stalls released; return to RUN.
  - redirect/interrupt_req are ignored while frozen. A redirect is re-evaluated next cycle because EX is held.
- Interrupt:
  - In RUN with interrupt_req = 1, int_active = 0 and no mem wait: go to INT_DRAIN, counter := 0.
  - INT_DRAIN: pc_stall = 1, if_id_flush = 1 each cycle. Counter increments; a mem wait freezes the counter and applies the full freeze. Redirects flush normally. At counter == DRAIN_CYCLES - 1, go to INT_ENTER.
  - INT_ENTER (1 cycle): int_ack = 1, if_id_flush = 1, pc_stall = 0 (PC loads vector). int_active := 1. Return to RUN.
  - interrupt_req while int_active = 1 is ignored; no nesting.
- Reset asserted mid-wait or mid-drain aborts immediately to RUN with all outputs 0.

Decomposition:
- Package hazard_pkg: state enum (RUN, MEM_WAIT, INT_DRAIN, INT_ENTER); fwd_sel encodings FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2; REG_ZERO = 4'd0.
- Sub-module fwd_unit: purely combinational forwarding compare, instantiated twice (rs1, rs2).

Test Plan:
- Load-use: EX load ex_reg_dst = 5, ex_wb_sel = 1; ID rs1 = 5 used -> one cycle of pc_stall = 1, if_id_stall = 1, id_ex_flush = 1; next cycle all 0. Repeat with dst = 0 -> no stall.
- Forwarding: mem_reg_dst = 3 wr = 1 and wb_reg_dst = 3 wr = 1, id_rs2 = 3 -> fwd_sel_rs2 = 1. Drop mem_reg_wr -> 2. id_rs2 = 4 -> 0.
- Redirect coincident with load-use: redirect_ex = 1 -> if_id_flush = id_ex_flush = 1, pc_stall = 0.
- Mem wait: mem_req = 1, mem_ready = 0 for 4 cycles then 1 -> all stalls = 1 for 4 cycles, released in the ready cycle, mem_err never 1. With ready held 0 and MEM_TIMEOUT = 8 -> mem_err pulses in the 8th wait cycle together with mem_wb_flush.
- Interrupt: interrupt_req = 1 in RUN, DRAIN_CYCLES = 3 -> 3 cycles of pc_stall = 1 with if_id_flush = 1, then int_ack = 1 for 1 cycle, int_active = 1. Second request ignored. returni_ex -> int_active = 0 next cycle.
- Reset during MEM_WAIT: rst_n low for 1 cycle -> all outputs 0 immediately; state RUN after release.
